// File: rtl/axis_frame_pkg.sv
// Shared constants for the AXI-Stream frame transmitter.
// Default frame is one 28x28 MNIST image of 8-bit pixels.
package axis_frame_pkg;

    localparam int IMG_W           = 28;
    localparam int IMG_H           = 28;
    localparam int MNIST_FRAME_LEN = IMG_W * IMG_H;
    localparam int PIX_W           = 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

endpackage

// File: rtl/axis_tx_fifo2.sv
// Two-entry register FIFO; the head entry is a register that drives
// the stream data directly.
module axis_tx_fifo2
    import axis_frame_pkg::*;
#(
    parameter int W = PIX_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop_eff;

    assign pop_eff = pop_i && (cnt_q != 2'd0);
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign count_o = cnt_q;
    assign head_o  = head_q;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push_i, pop_eff})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = din_i;
                else               tail_d = din_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push/pop keeps the count; data shifts forward.
                if (cnt_q == 2'd1) begin
                    head_d = din_i;
                end else begin
                    head_d = tail_q;
                    tail_d = din_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/axis_frame_tx.sv
// Frame-buffer to AXI-Stream transmitter, one packet per start pulse.
// Define AXIS_TX_TUSER_SOF_EN to add a start-of-frame m_axis_tuser output.
module axis_frame_tx
    import axis_frame_pkg::*;
#(
    parameter int DATA_W    = PIX_W,
    parameter int FRAME_LEN = MNIST_FRAME_LEN,
    parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
`ifdef AXIS_TX_TUSER_SOF_EN
    ,
    output logic              m_axis_tuser
`endif
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] beat_q, beat_d;
    logic              inflight_q;
    logic              pop;
    logic              fifo_full, fifo_empty;
    logic [1:0]        fifo_cnt, occ;
    logic [DATA_W-1:0] head;

    axis_tx_fifo2 #(.W(DATA_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .din_i   (rd_data),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt),
        .head_o  (head)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = head;
    assign m_axis_tlast  = m_axis_tvalid && (beat_q == LAST);
`ifdef AXIS_TX_TUSER_SOF_EN
    assign m_axis_tuser  = m_axis_tvalid && (beat_q == '0);
`endif

    assign pop = m_axis_tvalid && m_axis_tready;

    // Stored words plus reads in flight never exceed the two FIFO slots.
    assign occ   = fifo_cnt + {1'b0, inflight_q};
    assign rd_en = (state_q == S_STREAM) &&
                   (pop || (!fifo_full && (occ < 2'd2)));

    assign rd_addr = raddr_q;
    assign busy    = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign done    = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    raddr_d = '0;
                end
            end
            S_STREAM: begin
                if (rd_en && (raddr_q == LAST)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && m_axis_tlast) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (rd_en && (raddr_q != LAST)) raddr_d = raddr_q + 1'b1;
        if (pop) beat_d = m_axis_tlast ? '0 : beat_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            raddr_q    <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            raddr_q    <= raddr_d;
            beat_q     <= beat_d;
            inflight_q <= rd_en;
        end
    end

endmodule

// File: tb/tb_axis_frame_tx.sv
// Bench for axis_frame_tx: a 4-beat instance for directed scenarios and
// a default 784-beat instance driven with random memory and tready.
module tb_axis_frame_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic       start4 = 1'b0, tready4 = 1'b0;
    logic       busy4, done4, rd_en4, tvalid4, tlast4;
    logic [1:0] rd_addr4;
    logic [7:0] rd_data4 = 8'h00, tdata4;

    logic       startB = 1'b0, treadyB = 1'b0;
    logic       busyB, doneB, rd_enB, tvalidB, tlastB;
    logic [9:0] rd_addrB;
    logic [7:0] rd_dataB = 8'h00, tdataB;
`ifdef AXIS_TX_TUSER_SOF_EN
    logic       tuser4, tuserB;
    logic       qBu[$];
`endif

    logic [7:0] memB[784];
    logic [7:0] q4d[$];
    logic       q4l[$];
    logic [1:0] ra4[$];
    logic [7:0] qBd[$];
    logic       qBl[$];
    int         done4_n = 0, doneB_n = 0, rdB_n = 0;

    axis_frame_tx #(.FRAME_LEN(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
        .rd_en(rd_en4), .rd_addr(rd_addr4), .rd_data(rd_data4),
        .m_axis_tdata(tdata4), .m_axis_tvalid(tvalid4),
        .m_axis_tready(tready4), .m_axis_tlast(tlast4)
`ifdef AXIS_TX_TUSER_SOF_EN
        , .m_axis_tuser(tuser4)
`endif
    );

    axis_frame_tx u_dutB (
        .clk(clk), .rst(rst), .start(startB), .busy(busyB), .done(doneB),
        .rd_en(rd_enB), .rd_addr(rd_addrB), .rd_data(rd_dataB),
        .m_axis_tdata(tdataB), .m_axis_tvalid(tvalidB),
        .m_axis_tready(treadyB), .m_axis_tlast(tlastB)
`ifdef AXIS_TX_TUSER_SOF_EN
        , .m_axis_tuser(tuserB)
`endif
    );

    // Synchronous-read memories and handshake monitors.
    always @(posedge clk) begin
        if (rd_en4) begin
            rd_data4 <= 8'h10 + {6'b0, rd_addr4};
            ra4.push_back(rd_addr4);
        end
        if (tvalid4 && tready4) begin
            q4d.push_back(tdata4);
            q4l.push_back(tlast4);
        end
        if (done4) done4_n <= done4_n + 1;
        if (rd_enB) begin
            rd_dataB <= memB[rd_addrB];
            rdB_n <= rdB_n + 1;
        end
        if (tvalidB && treadyB) begin
            qBd.push_back(tdataB);
            qBl.push_back(tlastB);
`ifdef AXIS_TX_TUSER_SOF_EN
            qBu.push_back(tuserB);
`endif
        end
        if (doneB) doneB_n <= doneB_n + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick(); tick();
        n_chk++;
        if ({busy4, done4, rd_en4, tvalid4, tlast4, rd_addr4, tdata4} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_dut4 got %b exp 0", {busy4, done4, rd_en4, tvalid4, tlast4, rd_addr4, tdata4});
        end
        n_chk++;
        if ({busyB, doneB, rd_enB, tvalidB, tlastB, rd_addrB, tdataB} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_dutB got %b exp 0", {busyB, doneB, rd_enB, tvalidB, tlastB, rd_addrB, tdataB});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic er, ev, el, ed, eb;
        tick();
        start4 = 1'b1;
        tready4 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            start4 = 1'b0;
            er = (c >= 1 && c <= 4);
            ev = (c >= 3 && c <= 6);
            el = (c == 6);
            ed = (c == 7);
            eb = (c >= 1 && c <= 6);
            n_chk++;
            if ({rd_en4, tvalid4, tlast4, done4, busy4} !== {er, ev, el, ed, eb}) begin
                n_fail++;
                $display("FAIL basic_ctrl c=%0d got rd/v/l/d/b=%b exp %b", c, {rd_en4, tvalid4, tlast4, done4, busy4}, {er, ev, el, ed, eb});
            end
            if (er) begin
                n_chk++;
                if (rd_addr4 !== 2'(c - 1)) begin
                    n_fail++;
                    $display("FAIL basic_addr c=%0d got %0d exp %0d", c, rd_addr4, c - 1);
                end
            end
            if (ev) begin
                n_chk++;
                if (tdata4 !== 8'(8'h10 + c - 3)) begin
                    n_fail++;
                    $display("FAIL basic_data c=%0d got %h exp %h", c, tdata4, 8'(8'h10 + c - 3));
                end
            end
        end
    endtask

    task automatic test_backpressure_toggle();
        int qb, db;
        logic stall, pl;
        logic [7:0] pd;
        qb = q4d.size();
        db = done4_n;
        stall = 1'b0;
        pd = 8'h00;
        pl = 1'b0;
        tick();
        start4 = 1'b1;
        tready4 = 1'b1;
        for (int c = 1; c < 40 && done4_n == db; c++) begin
            tick();
            start4 = 1'b0;
            if (stall) begin
                n_chk++;
                if (tvalid4 !== 1'b1 || tdata4 !== pd || tlast4 !== pl) begin
                    n_fail++;
                    $display("FAIL toggle_stall c=%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", c, tvalid4, tdata4, tlast4, pd, pl);
                end
            end
            tready4 = ~tready4;
            stall = tvalid4 && !tready4;
            pd = tdata4;
            pl = tlast4;
        end
        tready4 = 1'b1;
        tick(); tick();
        n_chk++;
        if (done4_n - db != 1) begin
            n_fail++;
            $display("FAIL toggle_done got %0d exp 1", done4_n - db);
        end
        n_chk++;
        if (q4d.size() - qb != 4) begin
            n_fail++;
            $display("FAIL toggle_beats got %0d exp 4", q4d.size() - qb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (q4d[qb+i] !== 8'(8'h10 + i) || q4l[qb+i] !== (i == 3)) begin
                    n_fail++;
                    $display("FAIL toggle_beat%0d got %h/%b exp %h/%b", i, q4d[qb+i], q4l[qb+i], 8'(8'h10 + i), i == 3);
                end
            end
        end
    endtask

    task automatic test_stall10();
        int qb, rb, db;
        qb = q4d.size();
        rb = ra4.size();
        db = done4_n;
        tick();
        start4 = 1'b1;
        tready4 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start4 = 1'b0;
            if (c >= 3) begin
                n_chk++;
                if (tvalid4 !== 1'b1 || tdata4 !== 8'h10 || tlast4 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_hold c=%0d got v=%b d=%h l=%b exp v=1 d=10 l=0", c, tvalid4, tdata4, tlast4);
                end
            end
        end
        n_chk++;
        if (ra4.size() - rb != 2) begin
            n_fail++;
            $display("FAIL stall_reads got %0d exp 2", ra4.size() - rb);
        end else begin
            n_chk++;
            if (ra4[rb] !== 2'd0 || ra4[rb+1] !== 2'd1) begin
                n_fail++;
                $display("FAIL stall_addrs got %0d,%0d exp 0,1", ra4[rb], ra4[rb+1]);
            end
        end
        tready4 = 1'b1;
        for (int c = 0; c < 30 && done4_n == db; c++) tick();
        n_chk++;
        if (done4_n - db != 1 || q4d.size() - qb != 4) begin
            n_fail++;
            $display("FAIL stall_release got done=%0d beats=%0d exp 1,4", done4_n - db, q4d.size() - qb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (q4d[qb+i] !== 8'(8'h10 + i) || q4l[qb+i] !== (i == 3)) begin
                    n_fail++;
                    $display("FAIL stall_beat%0d got %h/%b exp %h/%b", i, q4d[qb+i], q4l[qb+i], 8'(8'h10 + i), i == 3);
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        int qb, rb, db;
        for (int f = 0; f < 2; f++) begin
            qb = q4d.size();
            rb = ra4.size();
            db = done4_n;
            tick();
            start4 = 1'b1;
            tready4 = 1'b1;
            for (int c = 1; c <= 12; c++) begin
                tick();
                start4 = (f == 0) && (c == 2 || c == 4 || c == 6);
            end
            n_chk++;
            if (done4_n - db != 1 || q4d.size() - qb != 4 || ra4.size() - rb != 4) begin
                n_fail++;
                $display("FAIL busy_start f=%0d got done=%0d beats=%0d reads=%0d exp 1,4,4", f, done4_n - db, q4d.size() - qb, ra4.size() - rb);
            end else begin
                for (int i = 0; i < 4; i++) begin
                    n_chk++;
                    if (ra4[rb+i] !== 2'(i) || q4d[qb+i] !== 8'(8'h10 + i)) begin
                        n_fail++;
                        $display("FAIL busy_frame f=%0d i=%0d got a=%0d d=%h exp a=%0d d=%h", f, i, ra4[rb+i], q4d[qb+i], i, 8'(8'h10 + i));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int qb, rb, db;
        qb = q4d.size();
        tick();
        start4 = 1'b1;
        tready4 = 1'b1;
        for (int c = 0; c < 20 && q4d.size() - qb < 2; c++) begin
            tick();
            start4 = 1'b0;
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if ({busy4, done4, rd_en4, tvalid4, tlast4, rd_addr4, tdata4} !== 15'd0) begin
            n_fail++;
            $display("FAIL async_reset got %b exp 0", {busy4, done4, rd_en4, tvalid4, tlast4, rd_addr4, tdata4});
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        qb = q4d.size();
        rb = ra4.size();
        db = done4_n;
        start4 = 1'b1;
        for (int c = 0; c < 30 && done4_n == db; c++) begin
            tick();
            start4 = 1'b0;
        end
        n_chk++;
        if (done4_n - db != 1 || q4d.size() - qb != 4 || ra4.size() - rb != 4) begin
            n_fail++;
            $display("FAIL reset_restart got done=%0d beats=%0d reads=%0d exp 1,4,4", done4_n - db, q4d.size() - qb, ra4.size() - rb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (ra4[rb+i] !== 2'(i) || q4d[qb+i] !== 8'(8'h10 + i) || q4l[qb+i] !== (i == 3)) begin
                    n_fail++;
                    $display("FAIL reset_frame i=%0d got a=%0d d=%h l=%b exp a=%0d d=%h l=%b", i, ra4[rb+i], q4d[qb+i], q4l[qb+i], i, 8'(8'h10 + i), i == 3);
                end
            end
        end
    endtask

    task automatic test_random_frame();
        int qb, rb, db, pr;
        logic stall, pl;
        logic [7:0] pd;
        for (int i = 0; i < 784; i++) memB[i] = 8'($urandom);
        qb = qBd.size();
        rb = rdB_n;
        db = doneB_n;
        stall = 1'b0;
        pd = 8'h00;
        pl = 1'b0;
        pr = 0;
        tick();
        startB = 1'b1;
        treadyB = ($urandom_range(0, 99) < 70);
        for (int c = 1; c < 6000 && doneB_n == db; c++) begin
            tick();
            startB = 1'b0;
            n_chk++;
            if ((rdB_n - rb) - (qBd.size() - qb) > 2) begin
                n_fail++;
                if (pr++ < 10) $display("FAIL rand_outstanding c=%0d got %0d exp <=2", c, (rdB_n - rb) - (qBd.size() - qb));
            end
            if (stall) begin
                n_chk++;
                if (tvalidB !== 1'b1 || tdataB !== pd || tlastB !== pl) begin
                    n_fail++;
                    if (pr++ < 10) $display("FAIL rand_stall c=%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", c, tvalidB, tdataB, tlastB, pd, pl);
                end
            end
            treadyB = ($urandom_range(0, 99) < 70);
            stall = tvalidB && !treadyB;
            pd = tdataB;
            pl = tlastB;
        end
        treadyB = 1'b0;
        tick(); tick();
        n_chk++;
        if (doneB_n - db != 1) begin
            n_fail++;
            $display("FAIL rand_done got %0d exp 1", doneB_n - db);
        end
        n_chk++;
        if (qBd.size() - qb != 784) begin
            n_fail++;
            $display("FAIL rand_beats got %0d exp 784", qBd.size() - qb);
        end else begin
            for (int i = 0; i < 784; i++) begin
                n_chk++;
                if (qBd[qb+i] !== memB[i] || qBl[qb+i] !== (i == 783)) begin
                    n_fail++;
                    if (pr++ < 10) $display("FAIL rand_beat%0d got %h/%b exp %h/%b", i, qBd[qb+i], qBl[qb+i], memB[i], i == 783);
                end
`ifdef AXIS_TX_TUSER_SOF_EN
                n_chk++;
                if (qBu[qb+i] !== (i == 0)) begin
                    n_fail++;
                    if (pr++ < 10) $display("FAIL rand_tuser%0d got %b exp %b", i, qBu[qb+i], i == 0);
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure_toggle();
        test_stall10();
        test_start_while_busy();
        test_reset_mid_frame();
        test_random_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
